// File: rtl/math_add_pipe.sv
// Pipelined add/subtract with a segmented carry chain: one SEG-bit slice per stage.
// Define MATH_ADD_PIPE_OVF_EN to add the two's-complement overflow output ovf.
module math_add_pipe #(
    parameter int WIDTH = 96,
    parameter int SEG   = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             in_valid,
    input  logic             in_sub,
    input  logic [WIDTH-1:0] dina,
    input  logic [WIDTH-1:0] dinb,
    output logic             out_valid,
`ifdef MATH_ADD_PIPE_OVF_EN
    output logic [WIDTH:0]   dout,
    output logic             ovf
`else
    output logic [WIDTH:0]   dout
`endif
);

    localparam int NSEG = (WIDTH + SEG - 1) / SEG;

    // Slot k holds an operation whose segments 0..k-1 are already summed into s_p[k].
    logic [NSEG-1:0][WIDTH-1:0] a_p, b_p, s_p, s_nx;
    logic [NSEG-1:0]            c_p, c_nx, sub_p, v_p;

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        localparam int LO = k * SEG;
        localparam int W  = (k == NSEG - 1) ? WIDTH - LO : SEG;
        localparam logic [WIDTH-1:0] MASK = ((WIDTH'(1) << W) - WIDTH'(1)) << LO;
        logic [W:0] t;

        assign t         = {1'b0, a_p[k][LO +: W]} + {1'b0, b_p[k][LO +: W]} + {{W{1'b0}}, c_p[k]};
        assign s_nx[k]   = (s_p[k] & ~MASK) | (WIDTH'(t[W-1:0]) << LO);
        assign c_nx[k]   = t[W];
    end

`ifdef MATH_ADD_PIPE_OVF_EN
    // b_p already carries ~dinb for subtraction, so one equal-sign test covers both ops.
    logic ovf_nx;
    assign ovf_nx = (a_p[NSEG-1][WIDTH-1] == b_p[NSEG-1][WIDTH-1]) &&
                    (s_nx[NSEG-1][WIDTH-1] != a_p[NSEG-1][WIDTH-1]);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_p       <= '0;
            b_p       <= '0;
            s_p       <= '0;
            c_p       <= '0;
            sub_p     <= '0;
            v_p       <= '0;
            out_valid <= 1'b0;
            dout      <= '0;
`ifdef MATH_ADD_PIPE_OVF_EN
            ovf       <= 1'b0;
`endif
        end else if (ce) begin
            a_p[0]   <= dina;
            b_p[0]   <= in_sub ? ~dinb : dinb;
            s_p[0]   <= '0;
            c_p[0]   <= in_sub;
            sub_p[0] <= in_sub;
            v_p[0]   <= in_valid;
            for (int j = 1; j < NSEG; j++) begin
                a_p[j]   <= a_p[j-1];
                b_p[j]   <= b_p[j-1];
                s_p[j]   <= s_nx[j-1];
                c_p[j]   <= c_nx[j-1];
                sub_p[j] <= sub_p[j-1];
                v_p[j]   <= v_p[j-1];
            end
            out_valid <= v_p[NSEG-1];
            // For subtraction the carry-out means "no borrow", so the top bit is its inverse.
            if (v_p[NSEG-1]) begin
                dout <= {c_nx[NSEG-1] ^ sub_p[NSEG-1], s_nx[NSEG-1]};
`ifdef MATH_ADD_PIPE_OVF_EN
                ovf  <= ovf_nx;
`endif
            end
        end
    end

endmodule
